mxu_operand_loader: RTL and testbench
=====================================

Name: mxu_operand_loader

Overview:
Parametrised operand staging unit feeding the MXU.
- Activation path: deserialises a valid/ready word stream from the input FIFO into a double-buffered COLUMNS-wide activation vector. The programmed column count is filled one word per column.
- Weight path: an address generator fetches ROWS weight words from weight memory into a row-wide weight vector.
- Both vectors are presented to the MXU with handshakes.

Parameters:
ROWS, 4, number of weight rows (1..32)
COLUMNS, 4, number of activation columns (1..32)
DATA_W, 64, width of one FIFO/memory word
ADDR_W, 16, weight memory address width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cfg_load  in  1  configuration strobe
cfg_ncols  in  $clog2(COLUMNS)+1  active column count
cfg_nrows  in  $clog2(ROWS)+1  active row count
cfg_wbase  in  ADDR_W  weight base address
cfg_err  out  1  pulse: cfg_load rejected
in_valid  in  1  FIFO word valid
in_data  in  DATA_W  FIFO word
in_ready  out  1  loader accepts word
act_data  out  DATA_W*COLUMNS  activation vector; column c at [c*DATA_W +: DATA_W]
act_valid  out  1  activation vector valid
act_ready  in  1  MXU consumes vector
w_start  in  1  start weight fetch
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  read data valid; in-order responses
weight_data  out  DATA_W*ROWS  weight vector; row r at [r*DATA_W +: DATA_W]
weight_valid  out  1  weight vector valid
weight_ack  in  1  MXU took weights
busy  out  1  any path non-idle

Behaviour:
- Reset: reset_n is synchronous, active-low. All outputs 0 except in_ready=1. Registers after reset:
  - ncols=COLUMNS, nrows=ROWS, wbase=0.
  - Both buffers cleared, counters 0, weight FSM in W_IDLE.
  - Reset asserted mid-operation discards all partial data; no further handshakes complete.
- Config:
  - cfg_load is accepted only when busy=0. On accept, registers latch next cycle.
  - If cfg_load arrives while busy=1, the config is ignored and cfg_err=1 for one cycle.
  - A count of 0, or a count above COLUMNS/ROWS, saturates to COLUMNS/ROWS.
- busy = shadow partially or fully filled | act_valid | weight FSM != W_IDLE.
- Activation shadow buffer:
  - col_cnt starts at 0. An in_valid&&in_ready beat writes shadow[col_cnt] and increments col_cnt.
  - When the beat writes column ncols-1, shadow_full is set next cycle and col_cnt returns to 0.
  - in_ready = !shadow_full (registered-only path; no combinational dependency on act_ready).
- Activation transfer:
  - Fires when shadow_full && (!act_valid || act_ready).
  - Actions: active <= shadow, columns >= ncols forced to 0, act_valid <= 1, shadow_full <= 0, shadow cleared.
  - Latency: last FIFO beat at cycle t gives act_valid at t+2 when the active buffer is free.
  - If act_valid && act_ready and no transfer fires, act_valid <= 0. act_data holds its value until the next transfer.
  - Filling the shadow continues while act_valid is waiting; full throughput is ncols words per ncols+1 cycles.
- Weight FSM:
  - W_IDLE: w_start -> W_REQ, req_cnt=0, rsp_cnt=0. mem_rvalid is ignored in W_IDLE.
  - W_REQ: mem_req=1, mem_addr=wbase+req_cnt (wraps modulo 2^ADDR_W), one request per cycle. After nrows requests -> W_WAIT.
  - W_REQ/W_WAIT: each mem_rvalid writes row[rsp_cnt] and increments rsp_cnt. The response for row nrows-1 moves the FSM to W_HOLD next cycle, with rows >= nrows zeroed. Responses may arrive during W_REQ.
  - W_HOLD: weight_valid=1, weight_data stable. weight_ack -> W_IDLE, weight_valid=0; weight_data retains its value.
  - w_start outside W_IDLE is ignored. w_start and weight_ack in the same cycle in W_HOLD: the ack is taken, the start is ignored.
- The activation and weight paths are independent and may run concurrently.

Optional Feature:
- Macro: MXU_OPERAND_LOADER_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_in_stall (32 bits): counts cycles with in_valid && !in_ready.
  - perf_out_stall (32 bits): counts cycles with act_valid && !act_ready.
  - Both counters saturate at 0xFFFFFFFF. They reset to 0 and clear on an accepted cfg_load.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then cfg_ncols=3 with COLUMNS=4; stream 0x11,0x22,0x33 with act_ready=1 -> act_valid pulses 2 cycles after the 3rd beat; columns = 0x11,0x22,0x33,0; in_ready low exactly 1 cycle.
- act_ready=0, stream 8 words with ncols=4 -> first vector held; shadow fills with words 5..8; in_ready=0 until act_ready=1; second vector follows the next cycle; no word lost or duplicated.
- cfg_wbase=0xFFFE, nrows=3, w_start; memory returns in-order data with latency 2 -> mem_addr sequence 0xFFFE,0xFFFF,0x0000; weight_valid with rows D0,D1,D2,0; held until weight_ack.
- cfg_load while act_valid=1 -> cfg_err=1 for one cycle; ncols unchanged. cfg_ncols=0 while idle -> ncols=COLUMNS.
- reset_n=0 for 1 cycle after 2 of 4 beats and during W_WAIT -> outputs return to reset values; the next 4-word stream produces a correct vector with no stale data.
- With MXU_OPERAND_LOADER_PERF_CNT_EN defined: hold act_ready=0 for 10 cycles while act_valid=1 -> perf_out_stall=10. An accepted cfg_load clears both counters.

Source files
------------

// File: rtl/mxu_operand_loader_if.sv
// Bus bundle between the MXU operand loader (slave) and its surroundings (master).
// Perf-counter outputs exist only when MXU_OPERAND_LOADER_PERF_CNT_EN is defined.
interface mxu_operand_loader_if #(
  parameter int ROWS    = 4,
  parameter int COLUMNS = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16
);
  logic                      cfg_load;
  logic [$clog2(COLUMNS):0]  cfg_ncols;
  logic [$clog2(ROWS):0]     cfg_nrows;
  logic [ADDR_W-1:0]         cfg_wbase;
  logic                      cfg_err;
  logic                      in_valid;
  logic [DATA_W-1:0]         in_data;
  logic                      in_ready;
  logic [DATA_W*COLUMNS-1:0] act_data;
  logic                      act_valid;
  logic                      act_ready;
  logic                      w_start;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_rvalid;
  logic [DATA_W*ROWS-1:0]    weight_data;
  logic                      weight_valid;
  logic                      weight_ack;
  logic                      busy;
`ifdef MXU_OPERAND_LOADER_PERF_CNT_EN
  logic [31:0]               perf_in_stall;
  logic [31:0]               perf_out_stall;
`endif

  modport master (
    output cfg_load, cfg_ncols, cfg_nrows, cfg_wbase, in_valid, in_data, act_ready,
           w_start, mem_rdata, mem_rvalid, weight_ack,
    input  cfg_err, in_ready, act_data, act_valid, mem_req, mem_addr, weight_data,
           weight_valid, busy
`ifdef MXU_OPERAND_LOADER_PERF_CNT_EN
    , input perf_in_stall, perf_out_stall
`endif
  );

  modport slave (
    input  cfg_load, cfg_ncols, cfg_nrows, cfg_wbase, in_valid, in_data, act_ready,
           w_start, mem_rdata, mem_rvalid, weight_ack,
    output cfg_err, in_ready, act_data, act_valid, mem_req, mem_addr, weight_data,
           weight_valid, busy
`ifdef MXU_OPERAND_LOADER_PERF_CNT_EN
    , output perf_in_stall, perf_out_stall
`endif
  );
endinterface

// File: rtl/mxu_operand_loader.sv
// MXU operand staging: double-buffered activation deserialiser plus weight-row fetcher.
// Optional stall counters are built when MXU_OPERAND_LOADER_PERF_CNT_EN is defined.
module mxu_operand_loader #(
  parameter int ROWS    = 4,
  parameter int COLUMNS = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  mxu_operand_loader_if.slave bus
);

  localparam int CC_W = $clog2(COLUMNS) + 1;
  localparam int RC_W = $clog2(ROWS) + 1;
  localparam logic [CC_W-1:0] NCOLS_MAX = CC_W'(COLUMNS);
  localparam logic [CC_W-1:0] ONE_C     = CC_W'(1);
  localparam logic [RC_W-1:0] NROWS_MAX = RC_W'(ROWS);
  localparam logic [RC_W-1:0] ONE_R     = RC_W'(1);

  typedef logic [COLUMNS-1:0][DATA_W-1:0] colvec_t;
  typedef logic [ROWS-1:0][DATA_W-1:0]    rowvec_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_HOLD} wstate_e;

  function automatic logic [CC_W-1:0] sat_ncols(input logic [CC_W-1:0] n);
    return ((n == '0) || (n > NCOLS_MAX)) ? NCOLS_MAX : n;
  endfunction

  function automatic logic [RC_W-1:0] sat_nrows(input logic [RC_W-1:0] n);
    return ((n == '0) || (n > NROWS_MAX)) ? NROWS_MAX : n;
  endfunction

  function automatic colvec_t mask_cols(input colvec_t v, input logic [CC_W-1:0] n);
    colvec_t m;
    m = v;
    for (int c = 0; c < COLUMNS; c++) if (CC_W'(c) >= n) m[c] = '0;
    return m;
  endfunction

  function automatic rowvec_t mask_rows(input rowvec_t v, input logic [RC_W-1:0] n);
    rowvec_t m;
    m = v;
    for (int r = 0; r < ROWS; r++) if (RC_W'(r) >= n) m[r] = '0;
    return m;
  endfunction

  logic [CC_W-1:0]   ncols_q;
  logic [RC_W-1:0]   nrows_q;
  logic [ADDR_W-1:0] wbase_q;
  logic              cfg_err_q;

  colvec_t           shadow_q, shadow_d;
  colvec_t           active_q, active_d;
  logic [CC_W-1:0]   col_cnt_q, col_cnt_d;
  logic              shadow_full_q, shadow_full_d;
  logic              act_valid_q, act_valid_d;

  wstate_e           wstate_q, wstate_d;
  logic [RC_W-1:0]   req_cnt_q, req_cnt_d;
  logic [RC_W-1:0]   rsp_cnt_q, rsp_cnt_d;
  rowvec_t           weight_q, weight_d;

  logic              busy;
  logic              cfg_accept;
  logic              in_ready;
  logic              beat;
  logic              xfer;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              weight_valid;

  assign busy       = (col_cnt_q != '0) || shadow_full_q || act_valid_q || (wstate_q != W_IDLE);
  assign cfg_accept = bus.cfg_load && !busy;
  // in_ready depends only on local state so the FIFO side never waits on the MXU combinationally
  assign in_ready   = !shadow_full_q;
  assign beat       = bus.in_valid && in_ready;
  assign xfer       = shadow_full_q && (!act_valid_q || bus.act_ready);

  always_comb begin
    shadow_d      = shadow_q;
    col_cnt_d     = col_cnt_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    act_valid_d   = act_valid_q;
    if (beat) begin
      for (int c = 0; c < COLUMNS; c++) if (CC_W'(c) == col_cnt_q) shadow_d[c] = bus.in_data;
      if (col_cnt_q == ncols_q - ONE_C) begin
        col_cnt_d     = '0;
        shadow_full_d = 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + ONE_C;
      end
    end
    if (xfer) begin
      active_d      = mask_cols(shadow_q, ncols_q);
      act_valid_d   = 1'b1;
      shadow_full_d = 1'b0;
      shadow_d      = '0;
    end else if (act_valid_q && bus.act_ready) begin
      act_valid_d = 1'b0;
    end
  end

  always_comb begin
    wstate_d     = wstate_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    weight_d     = weight_q;
    mem_req      = 1'b0;
    mem_addr     = '0;
    weight_valid = 1'b0;
    unique case (wstate_q)
      W_IDLE: if (bus.w_start) begin
        wstate_d  = W_REQ;
        req_cnt_d = '0;
        rsp_cnt_d = '0;
      end
      W_REQ: begin
        mem_req   = 1'b1;
        mem_addr  = wbase_q + ADDR_W'(req_cnt_q);
        req_cnt_d = req_cnt_q + ONE_R;
        if (req_cnt_q == nrows_q - ONE_R) wstate_d = W_WAIT;
      end
      W_WAIT: ;
      W_HOLD: begin
        weight_valid = 1'b1;
        if (bus.weight_ack) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    // Responses can overtake the request phase, so both states capture read data
    if (((wstate_q == W_REQ) || (wstate_q == W_WAIT)) && bus.mem_rvalid) begin
      for (int r = 0; r < ROWS; r++) if (RC_W'(r) == rsp_cnt_q) weight_d[r] = bus.mem_rdata;
      rsp_cnt_d = rsp_cnt_q + ONE_R;
      if (rsp_cnt_q == nrows_q - ONE_R) begin
        weight_d = mask_rows(weight_d, nrows_q);
        wstate_d = W_HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ncols_q       <= NCOLS_MAX;
      nrows_q       <= NROWS_MAX;
      wbase_q       <= '0;
      cfg_err_q     <= 1'b0;
      shadow_q      <= '0;
      col_cnt_q     <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      act_valid_q   <= 1'b0;
      wstate_q      <= W_IDLE;
      req_cnt_q     <= '0;
      rsp_cnt_q     <= '0;
      weight_q      <= '0;
    end else begin
      if (cfg_accept) begin
        ncols_q <= sat_ncols(bus.cfg_ncols);
        nrows_q <= sat_nrows(bus.cfg_nrows);
        wbase_q <= bus.cfg_wbase;
      end
      cfg_err_q     <= bus.cfg_load && busy;
      shadow_q      <= shadow_d;
      col_cnt_q     <= col_cnt_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      act_valid_q   <= act_valid_d;
      wstate_q      <= wstate_d;
      req_cnt_q     <= req_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      weight_q      <= weight_d;
    end
  end

  assign bus.cfg_err      = cfg_err_q;
  assign bus.in_ready     = in_ready;
  assign bus.act_data     = active_q;
  assign bus.act_valid    = act_valid_q;
  assign bus.mem_req      = mem_req;
  assign bus.mem_addr     = mem_addr;
  assign bus.weight_data  = weight_q;
  assign bus.weight_valid = weight_valid;
  assign bus.busy         = busy;

`ifdef MXU_OPERAND_LOADER_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_in_q;
  logic [31:0] perf_out_q;

  always_ff @(posedge clk) begin
    if (!reset_n || cfg_accept) begin
      perf_in_q  <= '0;
      perf_out_q <= '0;
    end else begin
      if (bus.in_valid && !in_ready)      perf_in_q  <= sat_inc(perf_in_q);
      if (act_valid_q && !bus.act_ready) perf_out_q <= sat_inc(perf_out_q);
    end
  end

  assign bus.perf_in_stall  = perf_in_q;
  assign bus.perf_out_stall = perf_out_q;
`endif

endmodule

// File: tb/tb_mxu_operand_loader.sv
// Directed bench for mxu_operand_loader: activation vector table plus weight, config and reset sequences.
module tb_mxu_operand_loader;
  localparam int ROWS = 4, COLUMNS = 4, DATA_W = 64, ADDR_W = 16;

  logic clk;
  logic reset_n;
  mxu_operand_loader_if #(.ROWS(ROWS), .COLUMNS(COLUMNS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mxu_operand_loader #(.ROWS(ROWS), .COLUMNS(COLUMNS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]   ncols;
    int           nw;
    logic [255:0] w;
    logic [255:0] exp;
  } vec_t;

  vec_t        vt[6];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        last_beat;
  logic [63:0] wq[$];
  logic [255:0] got[$];
  logic [15:0] addr_log[$];
  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [63:0] p0_d = '0, p1_d = '0;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return 64'hD0D0_0000_0000_0000 | {48'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_in();
    bus.in_valid = (wq.size() > 0);
    bus.in_data  = (wq.size() > 0) ? wq[0] : 64'h0;
  endtask

  // One clock: record handshakes, advance the latency-2 memory model, refresh FIFO drive
  task automatic tick();
    logic        req;
    logic [15:0] addr;
    last_beat = bus.in_valid && bus.in_ready;
    if (bus.act_valid && bus.act_ready) got.push_back(bus.act_data);
    req  = bus.mem_req;
    addr = bus.mem_addr;
    if (req) addr_log.push_back(addr);
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rvalid = p1_v;
    bus.mem_rdata  = p1_d;
    p1_v = p0_v;
    p1_d = p0_d;
    p0_v = req;
    p0_d = mem_word(addr);
    if (last_beat && wq.size() > 0) void'(wq.pop_front());
    drive_in();
  endtask

  task automatic do_cfg(input logic [2:0] nc, input logic [2:0] nr, input logic [15:0] wb);
    bus.cfg_load  = 1'b1;
    bus.cfg_ncols = nc;
    bus.cfg_nrows = nr;
    bus.cfg_wbase = wb;
    tick();
    bus.cfg_load = 1'b0;
  endtask

  task automatic wait_vec(input int n, input int budget, input string nm);
    for (int k = 0; k < budget && got.size() < n; k++) tick();
    if (got.size() < n) chk({nm, "_timeout"}, 256'(got.size()), 256'(n));
  endtask

  task automatic setv(input int i, input logic [2:0] nc, input int nw, input logic [255:0] w,
                      input logic [255:0] e);
    vt[i].ncols = nc;
    vt[i].nw    = nw;
    vt[i].w     = w;
    vt[i].exp   = e;
  endtask

  initial begin
    int          nb, t_last, t_av, ir_low;
    logic [255:0] wexp;

    setv(0, 3'd3, 3, {64'h0, 64'h33, 64'h22, 64'h11}, {64'h0, 64'h33, 64'h22, 64'h11});
    setv(1, 3'd4, 4, {64'hA4, 64'hA3, 64'hA2, 64'hA1}, {64'hA4, 64'hA3, 64'hA2, 64'hA1});
    setv(2, 3'd1, 1, {64'h0, 64'h0, 64'h0, 64'h5A}, {64'h0, 64'h0, 64'h0, 64'h5A});
    setv(3, 3'd0, 4, {64'hB4, 64'hB3, 64'hB2, 64'hB1}, {64'hB4, 64'hB3, 64'hB2, 64'hB1});
    setv(4, 3'd7, 4, {64'hC4, 64'hC3, 64'hC2, 64'hC1}, {64'hC4, 64'hC3, 64'hC2, 64'hC1});
    setv(5, 3'd2, 2, {64'h0, 64'h0, 64'hD2, 64'hD1}, {64'h0, 64'h0, 64'hD2, 64'hD1});

    reset_n        = 1'b0;
    bus.cfg_load   = 1'b0;
    bus.cfg_ncols  = '0;
    bus.cfg_nrows  = '0;
    bus.cfg_wbase  = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.act_ready  = 1'b0;
    bus.w_start    = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.weight_ack = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_act_valid", 256'(bus.act_valid), 256'(0));
    chk("rst_act_data", 256'(bus.act_data), 256'(0));
    chk("rst_cfg_err", 256'(bus.cfg_err), 256'(0));
    chk("rst_mem_req", 256'(bus.mem_req), 256'(0));
    chk("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
    chk("rst_weight_valid", 256'(bus.weight_valid), 256'(0));
    chk("rst_weight_data", 256'(bus.weight_data), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    reset_n = 1'b1;
    tick();

    // Activation vector table: latency, in_ready bubble and data per programmed column count
    for (int i = 0; i < 6; i++) begin
      do_cfg(vt[i].ncols, 3'd4, 16'h0);
      bus.act_ready = 1'b1;
      got.delete();
      for (int k = 0; k < vt[i].nw; k++) wq.push_back(vt[i].w[k*64 +: 64]);
      drive_in();
      nb = 0; t_last = -1; t_av = -1; ir_low = 0;
      for (int k = 0; k < 30 && t_av < 0; k++) begin
        tick();
        if (last_beat) begin
          nb++;
          if (nb == vt[i].nw) t_last = cyc - 1;
        end
        if (t_last >= 0) begin
          if (!bus.in_ready) ir_low++;
          if (bus.act_valid) t_av = cyc;
        end
      end
      tick();
      chk($sformatf("vec%0d_latency", i), 256'(t_av - t_last), 256'(2));
      chk($sformatf("vec%0d_in_ready_low", i), 256'(ir_low), 256'(1));
      chk($sformatf("vec%0d_count", i), 256'(got.size()), 256'(1));
      chk($sformatf("vec%0d_data", i), (got.size() > 0) ? got[0] : 256'h0, vt[i].exp);
    end

    // Backpressure: second vector fills the shadow while the first waits
    do_cfg(3'd4, 3'd4, 16'h0);
    bus.act_ready = 1'b0;
    got.delete();
    for (int k = 1; k <= 8; k++) wq.push_back(64'(k));
    drive_in();
    for (int k = 0; k < 14; k++) tick();
    chk("bp_act_valid", 256'(bus.act_valid), 256'(1));
    chk("bp_first_vec", bus.act_data, {64'h4, 64'h3, 64'h2, 64'h1});
    chk("bp_in_ready", 256'(bus.in_ready), 256'(0));
    chk("bp_words_taken", 256'(wq.size()), 256'(0));
    bus.act_ready = 1'b1;
    tick();
    chk("bp_second_valid", 256'(bus.act_valid), 256'(1));
    chk("bp_second_vec", bus.act_data, {64'h8, 64'h7, 64'h6, 64'h5});
    chk("bp_in_ready_back", 256'(bus.in_ready), 256'(1));
    tick();
    bus.act_ready = 1'b0;
    chk("bp_vec_count", 256'(got.size()), 256'(2));
    chk("bp_got0", (got.size() > 0) ? got[0] : 256'h0, {64'h4, 64'h3, 64'h2, 64'h1});
    chk("bp_got1", (got.size() > 1) ? got[1] : 256'h0, {64'h8, 64'h7, 64'h6, 64'h5});
    chk("bp_idle", 256'({bus.act_valid, bus.busy}), 256'(0));

    // Weight fetch across the address wrap
    do_cfg(3'd4, 3'd3, 16'hFFFE);
    addr_log.delete();
    bus.w_start = 1'b1;
    tick();
    bus.w_start = 1'b0;
    for (int k = 0; k < 20 && !bus.weight_valid; k++) tick();
    wexp = {64'h0, 64'hD0D0_0000_0000_0000, 64'hD0D0_0000_0000_FFFF, 64'hD0D0_0000_0000_FFFE};
    chk("w_valid", 256'(bus.weight_valid), 256'(1));
    chk("w_nreq", 256'(addr_log.size()), 256'(3));
    chk("w_addr0", 256'((addr_log.size() > 0) ? addr_log[0] : 16'h1234), 256'(16'hFFFE));
    chk("w_addr1", 256'((addr_log.size() > 1) ? addr_log[1] : 16'h1234), 256'(16'hFFFF));
    chk("w_addr2", 256'((addr_log.size() > 2) ? addr_log[2] : 16'h1234), 256'(16'h0000));
    chk("w_data", bus.weight_data, wexp);
    for (int k = 0; k < 3; k++) tick();
    chk("w_hold_valid", 256'(bus.weight_valid), 256'(1));
    chk("w_hold_data", bus.weight_data, wexp);
    chk("w_hold_busy", 256'(bus.busy), 256'(1));
    bus.weight_ack = 1'b1;
    bus.w_start    = 1'b1;
    tick();
    bus.weight_ack = 1'b0;
    bus.w_start    = 1'b0;
    chk("w_ack_valid", 256'(bus.weight_valid), 256'(0));
    chk("w_ack_busy", 256'(bus.busy), 256'(0));
    chk("w_ack_no_restart", 256'(bus.mem_req), 256'(0));
    chk("w_ack_data_kept", bus.weight_data, wexp);

    // Config while busy is rejected and leaves ncols alone
    do_cfg(3'd1, 3'd4, 16'h0);
    bus.act_ready = 1'b0;
    got.delete();
    wq.push_back(64'h77);
    drive_in();
    for (int k = 0; k < 10 && !bus.act_valid; k++) tick();
    chk("cerr_act_valid", 256'(bus.act_valid), 256'(1));
    do_cfg(3'd2, 3'd4, 16'h0);
    chk("cerr_pulse", 256'(bus.cfg_err), 256'(1));
    tick();
    chk("cerr_single", 256'(bus.cfg_err), 256'(0));
    bus.act_ready = 1'b1;
    tick();
    got.delete();
    wq.push_back(64'h88);
    drive_in();
    wait_vec(1, 10, "cerr_vec");
    chk("cerr_ncols_kept", (got.size() > 0) ? got[0] : 256'h0, {64'h0, 64'h0, 64'h0, 64'h88});

    // Reset during a partial vector and during W_WAIT
    do_cfg(3'd4, 3'd4, 16'h0100);
    bus.act_ready = 1'b1;
    got.delete();
    wq.push_back(64'hE1);
    wq.push_back(64'hE2);
    drive_in();
    bus.w_start = 1'b1;
    tick();
    bus.w_start = 1'b0;
    for (int k = 0; k < 10 && bus.mem_req; k++) tick();
    chk("mr_pre_busy", 256'(bus.busy), 256'(1));
    chk("mr_pre_wvalid", 256'(bus.weight_valid), 256'(0));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr_in_ready", 256'(bus.in_ready), 256'(1));
    chk("mr_busy", 256'(bus.busy), 256'(0));
    chk("mr_act_data", bus.act_data, 256'h0);
    chk("mr_weight_data", bus.weight_data, 256'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("mr_late_rsp_ignored", 256'({bus.weight_valid, bus.busy, bus.mem_req}), 256'(0));
    for (int k = 1; k <= 4; k++) wq.push_back(64'hF0 + 64'(k));
    drive_in();
    wait_vec(1, 20, "mr_vec");
    for (int k = 0; k < 3; k++) tick();
    chk("mr_vec_count", 256'(got.size()), 256'(1));
    chk("mr_vec_data", (got.size() > 0) ? got[0] : 256'h0, {64'hF4, 64'hF3, 64'hF2, 64'hF1});

`ifdef MXU_OPERAND_LOADER_PERF_CNT_EN
    do_cfg(3'd1, 3'd4, 16'h0);
    bus.act_ready = 1'b0;
    wq.push_back(64'h99);
    drive_in();
    for (int k = 0; k < 10 && !bus.act_valid; k++) tick();
    for (int k = 0; k < 10; k++) tick();
    chk("perf_out_10", 256'(bus.perf_out_stall), 256'(10));
    chk("perf_in_0", 256'(bus.perf_in_stall), 256'(0));
    wq.push_back(64'h9A);
    wq.push_back(64'h9B);
    drive_in();
    for (int k = 0; k < 5; k++) tick();
    chk("perf_in_4", 256'(bus.perf_in_stall), 256'(4));
    chk("perf_out_15", 256'(bus.perf_out_stall), 256'(15));
    bus.act_ready = 1'b1;
    for (int k = 0; k < 20 && (bus.busy || wq.size() > 0); k++) tick();
    do_cfg(3'd4, 3'd4, 16'h0);
    chk("perf_clear", 256'({bus.perf_in_stall, bus.perf_out_stall}), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
